// File: rtl/branch_ctrl_rv32i_if.sv
// Decode/read-port/fetch bundle for the RV32I branch sequencer.
// BRANCH_CTRL_MISALIGN_TRAP_EN adds the res_misalign return signal.
interface branch_ctrl_rv32i_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ins;
  logic [XLEN-1:0] in_pc;
  logic            rf_req;
  logic [4:0]      rf_addr;
  logic            rf_gnt;
  logic [XLEN-1:0] rf_rdata;
  logic            res_valid;
  logic            res_ready;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_illegal;
  logic            res_err;
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
  logic            res_misalign;
`endif

  // master: the branch sequencer; slave: decode, arbiter and fetch around it
  modport master (
    input  in_valid, in_ins, in_pc, rf_gnt, rf_rdata, res_ready,
    output in_ready, rf_req, rf_addr, res_valid, res_taken, res_target,
           res_illegal, res_err
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
    , output res_misalign
`endif
  );

  modport slave (
    output in_valid, in_ins, in_pc, rf_gnt, rf_rdata, res_ready,
    input  in_ready, rf_req, rf_addr, res_valid, res_taken, res_target,
           res_illegal, res_err
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
    , input res_misalign
`endif
  );
endinterface

// File: rtl/branch_ctrl_rv32i.sv
// RV32I conditional-branch sequencer: two operand reads over one shared rf port, compare, return taken/target.
// Optional macro BRANCH_CTRL_MISALIGN_TRAP_EN flags taken branches to non-word-aligned targets.
module branch_ctrl_rv32i #(
  parameter int XLEN       = 32,
  parameter int RF_TIMEOUT = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_ctrl_rv32i_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, EVAL, RESP} state_t;

  localparam int TW = (RF_TIMEOUT > 1) ? $clog2(RF_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = (RF_TIMEOUT > 0) ? TW'(RF_TIMEOUT - 1) : '0;

  state_t          state_reg;
  logic            in_ready_reg;
  logic            rf_req_reg;
  logic [4:0]      rf_addr_reg;
  logic            res_valid_reg;
  logic            res_taken_reg;
  logic [XLEN-1:0] res_target_reg;
  logic            res_illegal_reg;
  logic            res_err_reg;
  logic [XLEN-1:0] pc_reg;
  logic [2:0]      funct3_reg;
  logic [4:0]      rs2_reg;
  logic [11:0]     imm_reg;
  logic [XLEN-1:0] opa_reg;
  logic [XLEN-1:0] opb_reg;
  logic [TW-1:0]   tmo_cnt_reg;
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
  logic            res_misalign_reg;
`endif

  logic            illegal_in;
  logic            cond;
  logic            rd_done;
  logic            rd_abort;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_branch;

  // funct3 = 010/011 are the only unassigned branch encodings
  assign illegal_in = (bus.in_ins[6:0] != 7'b1100011) || (bus.in_ins[14:13] == 2'b01);
  assign offset     = {{(XLEN-13){imm_reg[11]}}, imm_reg, 1'b0};
  assign pc_plus4   = pc_reg + XLEN'(4);
  assign pc_branch  = pc_reg + offset;

  // A read slot ends on a grant, or immediately when the register is x0 (no request raised)
  assign rd_done  = !rf_req_reg || bus.rf_gnt;
  assign rd_abort = (RF_TIMEOUT != 0) && rf_req_reg && !bus.rf_gnt && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    cond = 1'b0;
    case (funct3_reg)
      3'b000:  cond = (opa_reg == opb_reg);
      3'b001:  cond = (opa_reg != opb_reg);
      3'b100:  cond = ($signed(opa_reg) <  $signed(opb_reg));
      3'b101:  cond = ($signed(opa_reg) >= $signed(opb_reg));
      3'b110:  cond = (opa_reg <  opb_reg);
      3'b111:  cond = (opa_reg >= opb_reg);
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      in_ready_reg    <= 1'b1;
      rf_req_reg      <= 1'b0;
      rf_addr_reg     <= '0;
      res_valid_reg   <= 1'b0;
      res_taken_reg   <= 1'b0;
      res_target_reg  <= '0;
      res_illegal_reg <= 1'b0;
      res_err_reg     <= 1'b0;
      pc_reg          <= '0;
      funct3_reg      <= '0;
      rs2_reg         <= '0;
      imm_reg         <= '0;
      opa_reg         <= '0;
      opb_reg         <= '0;
      tmo_cnt_reg     <= '0;
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
      res_misalign_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_reg    <= 1'b0;
            pc_reg          <= bus.in_pc;
            funct3_reg      <= bus.in_ins[14:12];
            rs2_reg         <= bus.in_ins[24:20];
            imm_reg         <= {bus.in_ins[31], bus.in_ins[7], bus.in_ins[30:25], bus.in_ins[11:8]};
            opa_reg         <= '0;
            opb_reg         <= '0;
            tmo_cnt_reg     <= '0;
            res_taken_reg   <= 1'b0;
            res_err_reg     <= 1'b0;
            res_illegal_reg <= illegal_in;
            if (illegal_in) begin
              res_target_reg <= bus.in_pc + XLEN'(4);
              res_valid_reg  <= 1'b1;
              state_reg      <= RESP;
            end else begin
              rf_req_reg  <= (bus.in_ins[19:15] != 5'd0);
              rf_addr_reg <= bus.in_ins[19:15];
              state_reg   <= RD1;
            end
          end
        end
        RD1, RD2: begin
          if (rd_abort) begin
            rf_req_reg     <= 1'b0;
            rf_addr_reg    <= '0;
            res_err_reg    <= 1'b1;
            res_target_reg <= pc_plus4;
            res_valid_reg  <= 1'b1;
            state_reg      <= RESP;
          end else if (rd_done) begin
            tmo_cnt_reg <= '0;
            if (state_reg == RD1) begin
              if (rf_req_reg) opa_reg <= bus.rf_rdata;
              rf_req_reg  <= (rs2_reg != 5'd0);
              rf_addr_reg <= rs2_reg;
              state_reg   <= RD2;
            end else begin
              if (rf_req_reg) opb_reg <= bus.rf_rdata;
              rf_req_reg  <= 1'b0;
              rf_addr_reg <= '0;
              state_reg   <= EVAL;
            end
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          end
        end
        EVAL: begin
          res_taken_reg  <= cond;
          res_target_reg <= cond ? pc_branch : pc_plus4;
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
          res_misalign_reg <= cond && (pc_branch[1:0] != 2'b00);
`endif
          res_valid_reg  <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
            res_misalign_reg <= 1'b0;
`endif
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.rf_req      = rf_req_reg;
  assign bus.rf_addr     = rf_addr_reg;
  assign bus.res_valid   = res_valid_reg;
  assign bus.res_taken   = res_taken_reg;
  assign bus.res_target  = res_target_reg;
  assign bus.res_illegal = res_illegal_reg;
  assign bus.res_err     = res_err_reg;
`ifdef BRANCH_CTRL_MISALIGN_TRAP_EN
  assign bus.res_misalign = res_misalign_reg;
`endif
endmodule

// File: tb/tb_branch_ctrl_rv32i.sv
// Directed bench for branch_ctrl_rv32i: main instance with RF_TIMEOUT=0 and a second with RF_TIMEOUT=4.
module tb_branch_ctrl_rv32i;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold_gnt = 1'b0;
  logic [31:0] rf_mem [32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_ctrl_rv32i_if #(.XLEN(32)) bus ();
  branch_ctrl_rv32i_if #(.XLEN(32)) bus_t ();

  branch_ctrl_rv32i #(.XLEN(32), .RF_TIMEOUT(0)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  branch_ctrl_rv32i #(.XLEN(32), .RF_TIMEOUT(4)) u_tmo (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  // Register-file arbiter model: same-cycle grant unless held off
  assign bus.rf_gnt     = bus.rf_req & ~hold_gnt;
  assign bus.rf_rdata   = rf_mem[bus.rf_addr];
  assign bus_t.rf_gnt   = 1'b0;
  assign bus_t.rf_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction, wait for res_valid (bounded), check result, then handshake.
  task automatic run_ins(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input int exp_lat, input logic exp_taken, input logic [31:0] exp_target,
                         input logic exp_illegal, input int exp_ngnt, input logic [31:0] exp_addrs);
    int cyc;
    int ngnt;
    logic [31:0] addrs;
    bus.in_valid = 1'b1;
    bus.in_ins   = ins;
    bus.in_pc    = pc;
    tick();
    bus.in_valid = 1'b0;
    cyc = 1;
    ngnt = 0;
    addrs = 32'h0;
    while (!bus.res_valid && cyc < 20) begin
      if (bus.rf_req && bus.rf_gnt) begin
        ngnt++;
        addrs = (addrs << 5) | 32'(bus.rf_addr);
      end
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_taken"}, 32'(bus.res_taken), 32'(exp_taken));
    chk({tag, "_target"}, bus.res_target, exp_target);
    chk({tag, "_illegal"}, 32'(bus.res_illegal), 32'(exp_illegal));
    chk({tag, "_err"}, 32'(bus.res_err), 32'h0);
    chk({tag, "_ngnt"}, 32'(ngnt), 32'(exp_ngnt));
    chk({tag, "_addrs"}, addrs, exp_addrs);
    chk({tag, "_inrdy_busy"}, 32'(bus.in_ready), 32'h0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.res_valid), 32'h0);
    chk({tag, "_inrdy_back"}, 32'(bus.in_ready), 32'h1);
    $display("txn %s ins=%08h pc=%08h taken=%0d target=%08h lat=%0d", tag, ins, pc,
             exp_taken, exp_target, cyc);
  endtask

  initial begin
    int bad;
    logic [31:0] tgt0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h11;
    rf_mem[0] = 32'h0;
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd5;
    rf_mem[3] = 32'hFFFF_FFFF;
    rf_mem[4] = 32'd1;
    bus.in_valid = 1'b0;   bus.in_ins = '0;   bus.in_pc = '0;   bus.res_ready = 1'b0;
    bus_t.in_valid = 1'b0; bus_t.in_ins = '0; bus_t.in_pc = '0; bus_t.res_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_rf_req", 32'(bus.rf_req), 32'h0);
    chk("rst_rf_addr", 32'(bus.rf_addr), 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_res_target", bus.res_target, 32'h0);
    chk("rst_res_flags", {29'd0, bus.res_taken, bus.res_illegal, bus.res_err}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    run_ins("beq_taken",  32'h00208463, 32'h100, 4, 1'b1, 32'h108, 1'b0, 2, 32'h22);
    run_ins("blt_neg",    32'hFE41CEE3, 32'h200, 4, 1'b1, 32'h1FC, 1'b0, 2, 32'h64);
    run_ins("bltu_nt",    32'hFE41EEE3, 32'h200, 4, 1'b0, 32'h204, 1'b0, 2, 32'h64);
    run_ins("bge_nt",     32'hFE41DEE3, 32'h200, 4, 1'b0, 32'h204, 1'b0, 2, 32'h64);
    run_ins("bgeu_wrap",  32'hFE41FEE3, 32'h000, 4, 1'b1, 32'hFFFF_FFFC, 1'b0, 2, 32'h64);
    run_ins("bne_x0",     32'h00001863, 32'h300, 4, 1'b0, 32'h304, 1'b0, 0, 32'h0);
    run_ins("ill_f3",     32'h00002063, 32'h400, 1, 1'b0, 32'h404, 1'b1, 0, 32'h0);
    run_ins("ill_op",     32'h00208467, 32'h500, 1, 1'b0, 32'h504, 1'b1, 0, 32'h0);

    // Grant withheld 10 cycles on rs1, response back-pressured 3 cycles, busy in_valid ignored
    hold_gnt = 1'b1;
    bus.in_valid = 1'b1; bus.in_ins = 32'h00208463; bus.in_pc = 32'h100;
    tick();
    bus.in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rf_req !== 1'b1 || bus.rf_addr !== 5'd1 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    chk("stall_rd1_stable", 32'(bad), 32'h0);
    hold_gnt = 1'b0;
    chk("stall_rd1_addr", 32'(bus.rf_addr), 32'h1);
    tick();
    chk("stall_rd2_addr", 32'(bus.rf_addr), 32'h2);
    bus.in_valid = 1'b1; bus.in_ins = 32'hFE41CEE3; bus.in_pc = 32'h200;
    tick();
    chk("stall_eval_req", 32'(bus.rf_req), 32'h0);
    tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_taken !== 1'b1 || bus.res_target !== 32'h108 ||
          bus.in_ready !== 1'b0) bad++;
      tick();
    end
    chk("stall_res_stable", 32'(bad), 32'h0);
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("stall_handshake", {30'd0, bus.res_valid, bus.in_ready}, 32'h1);
    $display("txn stall ins=00208463 pc=00000100 gnt_wait=10 res_hold=3");

    // Reset while in RD2 aborts immediately
    bus.in_valid = 1'b1; bus.in_ins = 32'h00208463; bus.in_pc = 32'h100;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rd2_before_rst", 32'(bus.rf_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rf_req", 32'(bus.rf_req), 32'h0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    $display("txn reset_in_rd2");
    run_ins("post_rst",   32'h00208463, 32'h100, 4, 1'b1, 32'h108, 1'b0, 2, 32'h22);

    // Timeout instance: grant never arrives
    bus_t.in_valid = 1'b1; bus_t.in_ins = 32'h00208463; bus_t.in_pc = 32'h600;
    tick();
    bus_t.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("tmo_rd1_req", 32'(bus_t.rf_req), 32'h1);
    chk("tmo_not_yet", 32'(bus_t.res_valid), 32'h0);
    tick();
    chk("tmo_valid", 32'(bus_t.res_valid), 32'h1);
    chk("tmo_err", 32'(bus_t.res_err), 32'h1);
    chk("tmo_req_drop", 32'(bus_t.rf_req), 32'h0);
    chk("tmo_taken", 32'(bus_t.res_taken), 32'h0);
    tgt0 = bus_t.res_target;
    chk("tmo_target", tgt0, 32'h604);
    bus_t.res_ready = 1'b1;
    tick();
    bus_t.res_ready = 1'b0;
    chk("tmo_handshake", {30'd0, bus_t.res_valid, bus_t.in_ready}, 32'h1);
    $display("txn timeout ins=00208463 pc=00000600 err=%0d target=%08h", 1, tgt0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
